posit_normalise_pipe: RTL

//   Pipelined, parametrised post-add normaliser for the posit adder datapath.
//   - Takes the raw mantissa sum plus the interim regime/exponent from the aligner.
//   - Strips the hidden bit and folds the corrected exponent back into regime + exponent.
//   - Saturates to maxpos/minpos; flags zero and NaR.
//   - Sits between the adder core and the posit encoder; valid/ready on both sides.

---
 rtl/posit_normalise_pipe.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/posit_normalise_pipe.sv
// Post-add normaliser for the posit adder: strips the hidden bit, folds the
// corrected exponent back into regime/exponent and saturates to maxpos/minpos.
module posit_normalise_pipe #(
  parameter int unsigned N      = 16,
  parameter int unsigned MANT_W = 8,
  parameter int unsigned ES     = 1,
  parameter int unsigned REG_W  = 8,
  parameter int unsigned EXP_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MANT_W-1:0]        in_mant_sum,
  input  logic signed [REG_W-1:0]  in_regime,
  input  logic signed [EXP_W-1:0]  in_exp,
  input  logic                     in_nar,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MANT_W-1:0]        out_mant,
  output logic signed [REG_W-1:0]  out_regime,
  output logic [ES-1:0]            out_exp,
  output logic                     out_zero,
  output logic                     out_nar,
  output logic                     out_sat
);

  localparam int unsigned LZ_W   = $clog2(MANT_W + 1);
  localparam int unsigned AEXP_W = EXP_W + 1;
  localparam int unsigned TOT_W  = ((REG_W > EXP_W) ? REG_W : EXP_W) + ES + 2;
  localparam logic signed [TOT_W-1:0] REG_MAX = TOT_W'(N - 2);
  localparam logic signed [TOT_W-1:0] REG_MIN = -REG_MAX;

  logic                     w_s1_adv;
  logic                     w_s2_adv;
  logic [LZ_W-1:0]          w_nz;
  logic [MANT_W-1:0]        w_mant_shl;
  logic signed [AEXP_W-1:0] w_a_exp;

  logic                     r_s1_valid;
  logic [MANT_W-1:0]        r_s1_mant;
  logic signed [AEXP_W-1:0] r_s1_a_exp;
  logic signed [REG_W-1:0]  r_s1_regime;
  logic                     r_s1_nar;
  logic                     r_s1_zero;

  logic signed [TOT_W-1:0]  w_total;
  logic signed [TOT_W-1:0]  w_reg_full;
  logic [MANT_W-1:0]        w_mant;
  logic signed [REG_W-1:0]  w_regime;
  logic [ES-1:0]            w_exp;
  logic                     w_zero;
  logic                     w_nar;
  logic                     w_sat;

  assign w_s2_adv = !out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // S1: leading-zero count (MSB-first wins), hidden-bit strip, exponent correction
  always_comb begin
    w_nz = LZ_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (in_mant_sum[i]) w_nz = LZ_W'(MANT_W - 1 - i);
    end
    w_mant_shl = in_mant_sum << (w_nz + LZ_W'(1));
    w_a_exp    = AEXP_W'(in_exp) + AEXP_W'(1) - AEXP_W'(w_nz);
  end

  // S2: fold scale into regime/exponent, clamp, then NaR > zero > sat priority
  always_comb begin
    w_total    = (TOT_W'(r_s1_regime) <<< ES) + TOT_W'(r_s1_a_exp);
    w_reg_full = w_total >>> ES;
    w_mant     = r_s1_mant;
    w_regime   = REG_W'(w_reg_full);
    w_exp      = w_total[ES-1:0];
    w_zero     = 1'b0;
    w_nar      = 1'b0;
    w_sat      = 1'b0;
    if (r_s1_nar) begin
      w_mant   = '0;
      w_regime = '0;
      w_exp    = '0;
      w_nar    = 1'b1;
    end else if (r_s1_zero) begin
      w_mant   = '0;
      w_regime = '0;
      w_exp    = '0;
      w_zero   = 1'b1;
    end else if (w_reg_full > REG_MAX) begin
      w_mant   = '0;
      w_regime = REG_W'(REG_MAX);
      w_exp    = '0;
      w_sat    = 1'b1;
    end else if (w_reg_full < REG_MIN) begin
      w_mant   = '0;
      w_regime = REG_W'(REG_MIN);
      w_exp    = '0;
      w_sat    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_mant   <= '0;
      r_s1_a_exp  <= '0;
      r_s1_regime <= '0;
      r_s1_nar    <= 1'b0;
      r_s1_zero   <= 1'b0;
      out_valid   <= 1'b0;
      out_mant    <= '0;
      out_regime  <= '0;
      out_exp     <= '0;
      out_zero    <= 1'b0;
      out_nar     <= 1'b0;
      out_sat     <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_mant   <= w_mant_shl;
          r_s1_a_exp  <= w_a_exp;
          r_s1_regime <= in_regime;
          r_s1_nar    <= in_nar;
          r_s1_zero   <= (in_mant_sum == '0);
        end
      end
      // Output payload only changes when a new beat moves in, so a stalled beat holds
      if (w_s2_adv) begin
        out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          out_mant   <= w_mant;
          out_regime <= w_regime;
          out_exp    <= w_exp;
          out_zero   <= w_zero;
          out_nar    <= w_nar;
          out_sat    <= w_sat;
        end
      end
    end
  end

endmodule
